write_back_register_file: RTL and testbench
===========================================

Name: write_back_register_file

Overview:
- Consumer end of the memory-to-write-back pipeline interface: takes the MEM/WB register outputs and selects the write-back value (memory read data or ALU result).
- Commits that value into the 32-entry integer register file.
- Serves the decode stage through two read ports with same-cycle write-through bypass.
- Exports the selected write-back value so the execute-stage forwarding unit can use it.

Parameters:
DATA_WIDTH, 32, width of each register and of all data ports
ADDRESS_WIDTH, 5, register index width
REGISTER_COUNT, 32, number of architectural registers (index 0 hardwired zero)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all registers
writeBackFromMemoryOrAlu  input  1  write-back select: 1 = memoryReadData, 0 = aluData
memoryReadData  input  DATA_WIDTH  load data from MEM/WB register
aluData  input  DATA_WIDTH  ALU result from MEM/WB register
registerWriteEnable  input  1  commit write-back this cycle
rd  input  ADDRESS_WIDTH  destination register index
rs1  input  ADDRESS_WIDTH  read port 1 index (decode stage)
rs2  input  ADDRESS_WIDTH  read port 2 index (decode stage)
debugAddress  input  ADDRESS_WIDTH  testbench/debug read index
rs1Data  output  DATA_WIDTH  read port 1 data
rs2Data  output  DATA_WIDTH  read port 2 data
debugData  output  DATA_WIDTH  debug read data, no bypass
writeBackData  output  DATA_WIDTH  selected write-back value, to forwarding unit
writeBackValid  output  1  high when registerWriteEnable=1 and rd!=0

Behaviour:
- Storage: registers 1..REGISTER_COUNT-1, DATA_WIDTH each. Register 0 has no storage; reads of index 0 always return 0.
- writeBackData: combinational. Equals memoryReadData when writeBackFromMemoryOrAlu=1, otherwise aluData. It is driven regardless of registerWriteEnable.
- Write: on the rising clock edge, if registerWriteEnable=1 and rd!=0, register[rd] <= writeBackData. A write to rd=0 is silently dropped.
- Read ports: combinational.
  - rsXData = 0 if rsX=0.
  - Otherwise, if writeBackValid and rd==rsX, rsXData = writeBackData (write-through bypass, so a WB-stage write is visible to a same-cycle decode read).
  - Otherwise, rsXData = register[rsX].
- rs1 and rs2 may equal each other and rd at the same time; both ports return the bypassed value.
- debugData: register[debugAddress] (0 for index 0) with no bypass, so it reflects committed state only.
- Reset: asserting reset clears all registers to 0 immediately, independent of clock.
  - While reset is high, writes are blocked. rsXData and debugData return 0 unless the bypass condition holds; writeBackData and writeBackValid still follow the inputs combinationally.
  - A write coinciding with a reset assertion is lost.
  - After deassertion, the first rising edge with a valid write commits normally.
- Latency: write-back commit takes 1 cycle to storage; visibility on the read ports is 0 cycles (via bypass).
- No stall input. The upstream pipeline register holds or bubbles by driving registerWriteEnable=0.
- Arithmetic: none. All values pass through unmodified, with no sign or width changes.

Decomposition:
- Shared package (core-wide):
  - DATA_WIDTH, ADDRESS_WIDTH, REGISTER_COUNT constants.
  - ZERO_REGISTER index constant (0).
  - Write-back select encodings WRITE_BACK_FROM_MEMORY=1 and WRITE_BACK_FROM_ALU=0.
- One sub-module: write_back_mux, a pure 2:1 DATA_WIDTH select producing writeBackData. It is reused by the forwarding unit.
- The storage array, bypass logic and x0 handling stay in the top module.

Test Plan:
- Reset then read: assert reset mid-run after writing 0xDEADBEEF to x5 -> rs1=5 gives rs1Data=0 without any clock edge; debugData for every index = 0.
- ALU write-back: writeBackFromMemoryOrAlu=0, aluData=0x00000123, memoryReadData=0xFFFFFFFF, registerWriteEnable=1, rd=7; clock -> debugAddress=7 gives 0x00000123.
- Memory write-back: select=1, memoryReadData=0xCAFEF00D, rd=31; clock -> register 31 = 0xCAFEF00D; aluData ignored.
- x0 protection: rd=0, aluData=0x55555555, enable=1 -> writeBackValid=0; rs1=0 gives 0 before and after the edge; debug index 0 reads 0.
- Same-cycle bypass: x3 holds 0x11111111; drive rd=3, aluData=0x22222222, enable=1, rs1=rs2=3 -> rs1Data=rs2Data=0x22222222 before the edge; debugData(3)=0x11111111 until the edge, then 0x22222222.
- Disabled write: enable=0, rd=4, aluData=0xABCD0000, rs2=4 -> rs2Data keeps the old x4 value (0); no change after the edge; writeBackData still 0xABCD0000.

Source files
------------

// File: rtl/write_back_register_file_pkg.sv
// Core-wide constants shared by the write-back stage and the forwarding unit.
package write_back_register_file_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int ADDRESS_WIDTH  = 5;
    localparam int REGISTER_COUNT = 32;

    localparam logic [ADDRESS_WIDTH-1:0] ZERO_REGISTER = '0;

    localparam logic WRITE_BACK_FROM_MEMORY = 1'b1;
    localparam logic WRITE_BACK_FROM_ALU    = 1'b0;

endpackage

// File: rtl/write_back_register_file_mux.sv
// Write-back value select: load data or ALU result. Also used by the forwarding unit.
module write_back_mux
    import write_back_register_file_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             select,
    input  logic [WIDTH-1:0] memory_data,
    input  logic [WIDTH-1:0] alu_data,
    output logic [WIDTH-1:0] selected
);

    assign selected = (select == WRITE_BACK_FROM_MEMORY) ? memory_data : alu_data;

endmodule

// File: rtl/write_back_register_file.sv
// MEM/WB consumer: selects the write-back value, commits it to the integer
// register file and serves two bypassed decode read ports plus a debug port.
module write_back_register_file
    import write_back_register_file_pkg::*;
#(
    parameter int DATA_WIDTH     = write_back_register_file_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH  = write_back_register_file_pkg::ADDRESS_WIDTH,
    parameter int REGISTER_COUNT = write_back_register_file_pkg::REGISTER_COUNT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     writeBackFromMemoryOrAlu,
    input  logic [DATA_WIDTH-1:0]    memoryReadData,
    input  logic [DATA_WIDTH-1:0]    aluData,
    input  logic                     registerWriteEnable,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic [ADDRESS_WIDTH-1:0] debugAddress,
    output logic [DATA_WIDTH-1:0]    rs1Data,
    output logic [DATA_WIDTH-1:0]    rs2Data,
    output logic [DATA_WIDTH-1:0]    debugData,
    output logic [DATA_WIDTH-1:0]    writeBackData,
    output logic                     writeBackValid
);

    localparam logic [ADDRESS_WIDTH-1:0] ZERO_INDEX = ADDRESS_WIDTH'(ZERO_REGISTER);

    // x0 has no storage; index 0 is resolved to zero before the array is touched.
    logic [DATA_WIDTH-1:0] registers [1:REGISTER_COUNT-1];

    write_back_mux #(.WIDTH(DATA_WIDTH)) u_write_back_mux (
        .select      (writeBackFromMemoryOrAlu),
        .memory_data (memoryReadData),
        .alu_data    (aluData),
        .selected    (writeBackData)
    );

    assign writeBackValid = registerWriteEnable && (rd != ZERO_INDEX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < REGISTER_COUNT; i++)
                registers[i] <= '0;
        end else if (writeBackValid) begin
            registers[rd] <= writeBackData;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] committed(input logic [ADDRESS_WIDTH-1:0] index);
        committed = (index == ZERO_INDEX) ? '0 : registers[index];
    endfunction

    // Bypass lets a decode read in the same cycle see the value being written back.
    function automatic logic [DATA_WIDTH-1:0] bypassed(input logic [ADDRESS_WIDTH-1:0] index);
        if (index == ZERO_INDEX)
            bypassed = '0;
        else if (writeBackValid && (rd == index))
            bypassed = writeBackData;
        else
            bypassed = registers[index];
    endfunction

    assign rs1Data   = bypassed(rs1);
    assign rs2Data   = bypassed(rs2);
    assign debugData = committed(debugAddress);

endmodule

// File: tb/tb_write_back_register_file.sv
// Directed test-plan cases followed by random traffic against an array model.
module tb_write_back_register_file;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        writeBackFromMemoryOrAlu = 1'b0;
    logic [31:0] memoryReadData = '0;
    logic [31:0] aluData = '0;
    logic        registerWriteEnable = 1'b0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0, debugAddress = '0;
    logic [31:0] rs1Data, rs2Data, debugData, writeBackData;
    logic        writeBackValid;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [32];

    write_back_register_file dut (
        .clock(clock), .reset(reset),
        .writeBackFromMemoryOrAlu(writeBackFromMemoryOrAlu),
        .memoryReadData(memoryReadData), .aluData(aluData),
        .registerWriteEnable(registerWriteEnable), .rd(rd),
        .rs1(rs1), .rs2(rs2), .debugAddress(debugAddress),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .debugData(debugData),
        .writeBackData(writeBackData), .writeBackValid(writeBackValid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_wb();
        return writeBackFromMemoryOrAlu ? memoryReadData : aluData;
    endfunction

    function automatic logic exp_valid();
        return registerWriteEnable && rd != 0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (exp_valid() && rd == idx) return exp_wb();
        return model[idx];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rs1"}, rs1Data, exp_read(rs1));
        check({tag, ".rs2"}, rs2Data, exp_read(rs2));
        check({tag, ".dbg"}, debugData, debugAddress == 0 ? 32'h0 : model[debugAddress]);
        check({tag, ".wb"}, writeBackData, exp_wb());
        check({tag, ".valid"}, {31'h0, writeBackValid}, {31'h0, exp_valid()});
    endtask

    // Advance one cycle; model commits at the edge unless reset holds.
    task automatic tick();
        @(posedge clock);
        if (!reset && exp_valid()) model[rd] = exp_wb();
        @(negedge clock);
    endtask

    task automatic drive(input logic sel, input logic [31:0] mem, input logic [31:0] alu,
                         input logic en, input logic [4:0] d, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] dbg);
        writeBackFromMemoryOrAlu = sel;
        memoryReadData = mem;
        aluData = alu;
        registerWriteEnable = en;
        rd = d; rs1 = a; rs2 = b; debugAddress = dbg;
        #1;
    endtask

    initial begin
        clear_model();
        @(negedge clock);
        #1 check_all("por");
        @(negedge clock);
        reset = 1'b0;

        // Reset mid-run, no clock edge between assertion and readback
        drive(0, 32'h0, 32'hDEADBEEF, 1, 5, 0, 0, 5);
        tick();
        drive(0, 32'h0, 32'h0, 0, 0, 5, 0, 5);
        check("rst.pre_rs1", rs1Data, 32'hDEADBEEF);
        reset = 1'b1;
        clear_model();
        #1 check("rst.rs1", rs1Data, 32'h0);
        for (int i = 0; i < 32; i++) begin
            debugAddress = 5'(i);
            #0.01 check("rst.dbg", debugData, 32'h0);
        end
        @(negedge clock);
        reset = 1'b0;

        // ALU write-back
        drive(0, 32'hFFFFFFFF, 32'h00000123, 1, 7, 0, 0, 7);
        check_all("alu.pre");
        tick();
        drive(0, 32'h0, 32'h0, 0, 0, 0, 0, 7);
        check("alu.x7", debugData, 32'h00000123);

        // Memory write-back
        drive(1, 32'hCAFEF00D, 32'h12345678, 1, 31, 31, 0, 31);
        check_all("mem.pre");
        tick();
        drive(0, 32'h0, 32'h0, 0, 0, 0, 0, 31);
        check("mem.x31", debugData, 32'hCAFEF00D);

        // x0 protection
        drive(0, 32'h0, 32'h55555555, 1, 0, 0, 0, 0);
        check("x0.valid", {31'h0, writeBackValid}, 32'h0);
        check("x0.rs1_pre", rs1Data, 32'h0);
        tick();
        check("x0.rs1_post", rs1Data, 32'h0);
        check("x0.dbg", debugData, 32'h0);

        // Same-cycle bypass
        drive(0, 32'h0, 32'h11111111, 1, 3, 0, 0, 3);
        tick();
        drive(0, 32'h0, 32'h22222222, 1, 3, 3, 3, 3);
        check("byp.rs1", rs1Data, 32'h22222222);
        check("byp.rs2", rs2Data, 32'h22222222);
        check("byp.dbg_pre", debugData, 32'h11111111);
        @(posedge clock);
        model[3] = 32'h22222222;
        #1 check("byp.dbg_post", debugData, 32'h22222222);
        @(negedge clock);

        // Disabled write
        drive(0, 32'h0, 32'hABCD0000, 0, 4, 0, 4, 4);
        check("dis.rs2_pre", rs2Data, 32'h0);
        check("dis.wb", writeBackData, 32'hABCD0000);
        tick();
        check("dis.rs2_post", rs2Data, 32'h0);
        check("dis.dbg", debugData, 32'h0);

        // Random traffic, biased to low indices for frequent bypass hits
        for (int n = 0; n < 400; n++) begin
            logic narrow;
            narrow = ($urandom_range(0, 1) == 1);
            drive(1'($urandom), $urandom, $urandom, ($urandom_range(0, 3) != 0),
                  narrow ? 5'($urandom_range(0, 3)) : 5'($urandom),
                  narrow ? 5'($urandom_range(0, 3)) : 5'($urandom),
                  narrow ? 5'($urandom_range(0, 3)) : 5'($urandom),
                  5'($urandom));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                clear_model();
                #1 check_all("rnd.rst");
                tick();
                check_all("rnd.rst_hold");
                reset = 1'b0;
            end else begin
                check_all("rnd");
                tick();
            end
        end

        // Final sweep of committed state
        drive(0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            debugAddress = 5'(i);
            #1 check("sweep.dbg", debugData, model[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
